// File: rtl/mips_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_dbg_pkg
//  Description : Shared types and widths for the MIPS debug loader: host
//                command opcodes, loader FSM states, register-file and data
//                widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_dbg_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    // Host command opcodes carried on cmd_op
    typedef enum logic [1:0] {
        OP_WMEM = 2'b00,
        OP_WREG = 2'b01,
        OP_RUN  = 2'b10,
        OP_DUMP = 2'b11
    } cmd_op_t;

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_START    = 3'd2,
        ST_RUN      = 3'd3,
        ST_DUMP_RD  = 3'd4,
        ST_DUMP_OUT = 3'd5
    } state_t;

endpackage : mips_dbg_pkg
`default_nettype wire

// File: rtl/mips_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mips_loader
//  Description : Host-side debug loader for a small MIPS core. Accepts one
//                command at a time (memory write, register write, run until
//                halt, register dump) and sequences the core's write ports,
//                start pulse and register read port. Register dumps are
//                returned as a valid/ready beat stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_loader
    import mips_dbg_pkg::*;
#(
    parameter int MEM_AW      = 10,
    parameter int DUMP_CNT    = 6,
    parameter int RUN_TIMEOUT = 1024
) (
    input  logic              clk1,
    input  logic              reset,

    // host command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [MEM_AW-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,

    // core memory write port
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,

    // core register-file ports
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [REG_AW-1:0] reg_raddr,
    input  logic [DATA_W-1:0] reg_rdata,

    // core control
    output logic              core_start,
    input  logic              core_halted,

    // register dump stream
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [REG_AW-1:0] dump_idx,
    output logic              dump_last,

    // status
    output logic              busy,
    output logic              timeout_err
);

    // Run counter only ever needs to hold 0 .. RUN_TIMEOUT-1
    localparam int                c_run_cw   = (RUN_TIMEOUT < 2) ? 1 : $clog2(RUN_TIMEOUT);
    localparam logic [c_run_cw-1:0] c_run_last = c_run_cw'(RUN_TIMEOUT - 1);
    localparam logic [REG_AW-1:0] c_beat_last = REG_AW'(DUMP_CNT - 1);

    state_t              r_state;

    logic                r_mem_we;
    logic [MEM_AW-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                r_reg_we;
    logic [REG_AW-1:0]   r_reg_waddr;
    logic [DATA_W-1:0]   r_reg_wdata;

    logic                r_core_start;
    logic                r_timeout_err;
    logic [c_run_cw-1:0] r_run_cnt;

    // r_idx is the register currently being read; r_beat counts dump beats
    logic [REG_AW-1:0]   r_idx;
    logic [REG_AW-1:0]   r_beat;

    logic                r_dump_valid;
    logic [DATA_W-1:0]   r_dump_data;
    logic [REG_AW-1:0]   r_dump_idx;
    logic                r_dump_last;

    logic                w_idle;

    assign w_idle = (r_state == ST_IDLE);

    // Command sequencer: one FSM owning every registered output
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_reg_we      <= 1'b0;
            r_reg_waddr   <= '0;
            r_reg_wdata   <= '0;
            r_core_start  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_run_cnt     <= '0;
            r_idx         <= '0;
            r_beat        <= '0;
            r_dump_valid  <= 1'b0;
            r_dump_data   <= '0;
            r_dump_idx    <= '0;
            r_dump_last   <= 1'b0;
        end else begin
            // strobes are single-cycle unless re-armed below
            r_mem_we     <= 1'b0;
            r_reg_we     <= 1'b0;
            r_core_start <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op_t'(cmd_op))
                            OP_WMEM: begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= cmd_addr;
                                r_mem_wdata <= cmd_data;
                                r_state     <= ST_WRITE;
                            end
                            OP_WREG: begin
                                // index 0 is still written; the core ignores R0 writes
                                r_reg_we    <= 1'b1;
                                r_reg_waddr <= cmd_addr[REG_AW-1:0];
                                r_reg_wdata <= cmd_data;
                                r_state     <= ST_WRITE;
                            end
                            OP_RUN: begin
                                r_core_start  <= 1'b1;
                                r_timeout_err <= 1'b0;
                                r_state       <= ST_START;
                            end
                            OP_DUMP: begin
                                r_idx   <= cmd_addr[REG_AW-1:0];
                                r_beat  <= '0;
                                r_state <= ST_DUMP_RD;
                            end
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end

                // the write strobe is live during this cycle
                ST_WRITE: r_state <= ST_IDLE;

                // core_start is live during this cycle
                ST_START: begin
                    r_run_cnt <= '0;
                    r_state   <= ST_RUN;
                end

                // first RUN cycle may still show a stale HALTED, so it is ignored
                ST_RUN: begin
                    if ((r_run_cnt != '0) && core_halted) begin
                        r_state <= ST_IDLE;
                    end else if (r_run_cnt == c_run_last) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_run_cnt <= r_run_cnt + c_run_cw'(1);
                    end
                end

                // read port is combinational: capture the addressed register
                ST_DUMP_RD: begin
                    r_dump_valid <= 1'b1;
                    r_dump_data  <= reg_rdata;
                    r_dump_idx   <= r_idx;
                    r_dump_last  <= (r_beat == c_beat_last);
                    r_state      <= ST_DUMP_OUT;
                end

                // hold the beat until the host takes it
                ST_DUMP_OUT: begin
                    if (dump_ready) begin
                        r_dump_valid <= 1'b0;
                        r_dump_last  <= 1'b0;
                        r_idx        <= r_idx + REG_AW'(1);
                        r_beat       <= r_beat + REG_AW'(1);
                        r_state      <= (r_beat == c_beat_last) ? ST_IDLE : ST_DUMP_RD;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = w_idle;
    assign busy        = ~w_idle;
    assign timeout_err = r_timeout_err;

    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

    assign reg_we      = r_reg_we;
    assign reg_waddr   = r_reg_waddr;
    assign reg_wdata   = r_reg_wdata;
    assign reg_raddr   = r_idx;

    assign core_start  = r_core_start;

    assign dump_valid  = r_dump_valid;
    assign dump_data   = r_dump_data;
    assign dump_idx    = r_dump_idx;
    assign dump_last   = r_dump_last;

endmodule : mips_loader
`default_nettype wire

// File: doc/mips_loader.md
MIPS_LOADER -- requirements
Module: mips_loader

Interface
REQ-001 Parameter MEM_AW, default 10, instruction/data memory word-address width.
REQ-002 Parameter DUMP_CNT, default 6, number of registers returned per DUMP command, range 1..32.
REQ-003 Parameter RUN_TIMEOUT, default 1024, max cycles waited for core halt.
REQ-004 clk1  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake; transfer when both high on a clock edge.
REQ-007 cmd_op  in  2  00 WMEM, 01 WREG, 10 RUN, 11 DUMP.
REQ-008 cmd_addr  in  MEM_AW  memory word address (WMEM); low 5 bits are the register index (WREG) or start index (DUMP).
REQ-009 cmd_data  in  32  write data (WMEM/WREG); ignored otherwise.
REQ-010 mem_we, mem_addr, mem_wdata  out  1, MEM_AW, 32  core memory write port.
REQ-011 reg_we, reg_waddr, reg_wdata  out  1, 5, 32  core register-file write port.
REQ-012 reg_raddr  out  5; reg_rdata  in  32  core register read port, combinational read.
REQ-013 core_start  out  1  one-cycle pulse; core clears PC, HALTED and TAKEN_BRANCH.
REQ-014 core_halted  in  1  core HALTED flag.
REQ-015 dump_valid/dump_ready  out/in  1/1  readback stream handshake.
REQ-016 dump_data, dump_idx, dump_last  out  32, 5, 1  register value, register index, final beat.
REQ-017 busy, timeout_err  out  1, 1  not IDLE; sticky RUN timeout flag.

Function
REQ-018 FSM states IDLE, WRITE, START, RUN, DUMP_RD, DUMP_OUT; cmd_ready is high only in IDLE.
REQ-019 WMEM/WREG accepted in IDLE: next cycle in WRITE, exactly one mem_we or reg_we pulse with latched address/data, then IDLE; throughput one write per 2 cycles.
REQ-020 WREG to index 0 still pulses reg_we; R0 protection is the core's responsibility.
REQ-021 RUN accepted: START for 1 cycle with core_start=1, then RUN; run counter cleared at START.
REQ-022 RUN: core_halted sampled from the second cycle after START; when high, return to IDLE.
REQ-023 RUN: counter reaching RUN_TIMEOUT without halt sets timeout_err and returns to IDLE; timeout_err is cleared only by reset or the next accepted RUN.
REQ-024 DUMP accepted: index latched from cmd_addr[4:0], beat counter cleared; DUMP_RD drives reg_raddr=index and registers reg_rdata into dump_data.
REQ-025 DUMP_OUT: dump_valid=1; dump_data/dump_idx/dump_last held stable until dump_ready; on handshake, index increments modulo 32 (31 wraps to 0), then DUMP_RD, or IDLE after beat DUMP_CNT-1.
REQ-026 dump_last high only on beat DUMP_CNT-1.
REQ-027 Commands are not accepted while busy; cmd_valid held high outside IDLE has no effect.
REQ-028 mem_we, reg_we, core_start, dump_valid are never high in the same cycle.

Reset
REQ-029 reset overrides all state in any state, including mid-RUN and mid-DUMP: next state IDLE.
REQ-030 Reset values: cmd_ready=1, mem_we=0, reg_we=0, core_start=0, dump_valid=0, dump_last=0, busy=0, timeout_err=0, all address/data outputs 0.
REQ-031 A dump beat interrupted by reset is dropped and never re-issued.

Structure
REQ-032 Package mips_dbg_pkg holds the cmd_op enum, FSM state enum, REG_AW=5 and DATA_W=32.
REQ-033 Single module; no sub-module is warranted.

Verification
REQ-034 WMEM 0:2801000a, 1:28020014, 2:28030019, 3:0ce77800, 4:0ce77800, 5:00222000, 6:0ce77800, 7:00832800, 8:fc000000 -> nine mem_we pulses with matching addr/data, 2 cycles apart.
REQ-035 WREG k:k for k=0..30 then RUN -> single core_start pulse; IDLE after core_halted; timeout_err=0.
REQ-036 DUMP start 0 after run, dump_ready=1 -> beats R0..R5 = 0,10,20,25,30,55, dump_last only on idx 5.
REQ-037 DUMP start 30, DUMP_CNT=6, dump_ready toggled every other cycle -> idx 30,31,0,1,2,3; data stable while stalled.
REQ-038 RUN with core_halted stuck 0 -> timeout_err=1 after RUN_TIMEOUT cycles, IDLE; next RUN clears it.
REQ-039 reset asserted during beat 3 of a DUMP -> next cycle IDLE, dump_valid=0, cmd_ready=1.
